aftab_serial_comparator: RTL and testbench
==========================================

Name: aftab_serial_comparator

Overview:
- Multi-cycle, area-reduced operand comparator for the AFTAB datapath, for low-area build options where a single full-width compare is not affordable.
- Scans the operands one chunk per cycle, most-significant chunk first, and stops at the first differing chunk.
- Produces registered lt/eq/gt flags plus a one-cycle done pulse.
- Serves branch and set-less-than resolution through a start/busy/done handshake with the controller.

Parameters:
- size, 32, operand width in bits; must be a multiple of chunk.
- chunk, 8, bits compared per cycle; size/chunk must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  size  operand A; sampled on the accepted start
- b  input  size  operand B; sampled on the accepted start
- comparedSignedUnsignedBar  input  1  1 = signed two's-complement compare, 0 = unsigned; sampled on the accepted start
- busy  output  1  high in COMPARE and DONE
- done  output  1  one-cycle pulse; result valid
- lt  output  1  A < B
- eq  output  1  A == B
- gt  output  1  A > B

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, lt=0, eq=0, gt=0, index=0, operand registers=0.
- Operand encoding: on an accepted start, register aa and bb.
  - Signed mode: MSB of each operand is inverted.
  - Unsigned mode: operands are stored unchanged.
  - All later compares are unsigned on aa/bb.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 at an edge: latch aa/bb, index=size/chunk-1, clear lt/eq/gt to 0, go to COMPARE.
  - start=0: stay in IDLE, hold the previous lt/eq/gt.
- COMPARE, each cycle: compare chunk[index] of aa against bb.
  - aa chunk < bb chunk: lt=1, go to DONE.
  - aa chunk > bb chunk: gt=1, go to DONE.
  - Chunks equal and index==0: eq=1, go to DONE.
  - Chunks equal and index>0: index decrements, stay in COMPARE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- One-hot result: lt/eq/gt are one-hot from the DONE cycle until the next accepted start. They are all 0 while a compare is in progress.
- Latency:
  - With k chunks examined (1..size/chunk), done is high in cycle k+1 after the start edge.
  - Minimum 2 cycles; maximum size/chunk+1 cycles (5 with the defaults).
- start during COMPARE or DONE: ignored, not queued.
- Back-to-back operation: start may be high in the cycle after DONE (IDLE) and is accepted normally.
- Input stability: inputs a, b and mode may change freely after the accepted start; only the latched copies are used.
- Reset mid-operation: immediately returns to IDLE with all outputs 0; no done pulse is produced.
- Chunk order: MSB chunk is compared first. This is what makes early termination correct.

Decomposition:
- Shared package aftab_cmp_pkg:
  - state encodings CMP_IDLE=2'b00, CMP_COMPARE=2'b01, CMP_DONE=2'b10;
  - default constants CMP_SIZE=32, CMP_CHUNK=8.
- Sub-module aftab_chunk_compare #(chunk):
  - purely combinational, inputs x and y, outputs lt, eq, gt;
  - instantiated once and fed through an index-selected mux.

Test Plan:
- Signed, a=32'hFFFFFFFF, b=32'h00000001, start pulse -> lt=1, eq=0, gt=0, done 2 cycles after start (MSB chunk decides, 0x7F vs 0x80).
- Unsigned, same operands -> gt=1, done 2 cycles after start.
- Unsigned, a=b=32'h12345678 -> eq=1, done 5 cycles after start, busy high for 5 cycles.
- Signed, a=32'h80000000, b=32'h80000001 -> lt=1 after 4 chunks, done 5 cycles after start.
- start re-asserted with different operands during COMPARE:
  - ignored; the original result is reported;
  - a new start in the IDLE cycle after DONE is accepted.
- rst asserted during COMPARE at cycle 2 -> busy, done, lt, eq and gt are 0 immediately (asynchronously); no done pulse ever appears for the aborted compare.

Source files
------------

// File: rtl/aftab_cmp_pkg.sv
// Shared definitions for the AFTAB serial comparator: FSM state encoding and
// default operand/chunk widths.
package aftab_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE    = 2'b00,
    CMP_COMPARE = 2'b01,
    CMP_DONE    = 2'b10
  } cmpState_t;

  localparam int CMP_SIZE  = 32;
  localparam int CMP_CHUNK = 8;

endpackage

// File: rtl/aftab_chunk_compare.sv
// Combinational unsigned magnitude compare of one chunk; exactly one of
// lt/eq/gt is high for any input pair.
module aftab_chunk_compare
  import aftab_cmp_pkg::*;
#(
  parameter int chunk = CMP_CHUNK
) (
  input  logic [chunk-1:0] x,
  input  logic [chunk-1:0] y,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/aftab_serial_comparator.sv
// Area-reduced operand comparator: walks the latched operands one chunk per
// cycle, MSB chunk first, and stops at the first chunk that differs.
module aftab_serial_comparator
  import aftab_cmp_pkg::*;
#(
  parameter int size  = CMP_SIZE,
  parameter int chunk = CMP_CHUNK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            comparedSignedUnsignedBar,
  output logic            busy,
  output logic            done,
  output logic            lt,
  output logic            eq,
  output logic            gt
);

  localparam int NUM_CHUNKS = size / chunk;
  localparam int IDX_W      = $clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  cmpState_t        r_state;
  cmpState_t        w_nextState;
  logic [size-1:0]  r_aa;
  logic [size-1:0]  r_bb;
  logic [IDX_W-1:0] r_index;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;

  logic [chunk-1:0] w_aChunk;
  logic [chunk-1:0] w_bChunk;
  logic             w_chunkLt;
  logic             w_chunkEq;
  logic             w_chunkGt;
  logic [size-1:0]  w_aEnc;
  logic [size-1:0]  w_bEnc;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the chunk walk itself never needs to know the mode.
  assign w_aEnc = comparedSignedUnsignedBar ? {~a[size-1], a[size-2:0]} : a;
  assign w_bEnc = comparedSignedUnsignedBar ? {~b[size-1], b[size-2:0]} : b;

  assign w_aChunk = r_aa[r_index*chunk +: chunk];
  assign w_bChunk = r_bb[r_index*chunk +: chunk];

  aftab_chunk_compare #(
    .chunk(chunk)
  ) u_chunkCompare (
    .x (w_aChunk),
    .y (w_bChunk),
    .lt(w_chunkLt),
    .eq(w_chunkEq),
    .gt(w_chunkGt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CMP_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CMP_IDLE: begin
        if (start) begin
          w_nextState = CMP_COMPARE;
        end
      end
      CMP_COMPARE: begin
        if (w_chunkLt || w_chunkGt || (w_chunkEq && (r_index == '0))) begin
          w_nextState = CMP_DONE;
        end
      end
      CMP_DONE: begin
        w_nextState = CMP_IDLE;
      end
      default: begin
        w_nextState = CMP_IDLE;
      end
    endcase
  end

  // Flags stay cleared during the walk and are held in IDLE until the next
  // accepted start, so the result remains readable after the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aa    <= '0;
      r_bb    <= '0;
      r_index <= '0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      case (r_state)
        CMP_IDLE: begin
          if (start) begin
            r_aa    <= w_aEnc;
            r_bb    <= w_bEnc;
            r_index <= LAST_IDX;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
          end
        end
        CMP_COMPARE: begin
          if (w_chunkLt) begin
            r_lt <= 1'b1;
          end else if (w_chunkGt) begin
            r_gt <= 1'b1;
          end else if (r_index == '0) begin
            r_eq <= 1'b1;
          end else begin
            r_index <= r_index - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state == CMP_COMPARE) || (r_state == CMP_DONE);
  assign done = (r_state == CMP_DONE);
  assign lt   = r_lt;
  assign eq   = r_eq;
  assign gt   = r_gt;

endmodule

// File: tb/tb_aftab_serial_comparator.sv
// Randomised and directed self-checking bench for aftab_serial_comparator,
// checked against an arithmetic reference model of the compare and its latency.
module tb_aftab_serial_comparator;

  localparam int SIZE       = 32;
  localparam int CHUNK      = 8;
  localparam int NUM_CHUNKS = SIZE / CHUNK;
  localparam int TIMEOUT    = 20;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            mode;
  logic            busy;
  logic            done;
  logic            lt;
  logic            eq;
  logic            gt;

  int checkCount = 0;
  int errorCount = 0;

  aftab_serial_comparator #(
    .size (SIZE),
    .chunk(CHUNK)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .a                        (a),
    .b                        (b),
    .comparedSignedUnsignedBar(mode),
    .busy                     (busy),
    .done                     (done),
    .lt                       (lt),
    .eq                       (eq),
    .gt                       (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference result as {lt,eq,gt}, straight from integer ordering.
  function automatic logic [2:0] modelResult(input logic [SIZE-1:0] av,
                                             input logic [SIZE-1:0] bv,
                                             input logic signedMode);
    logic isLess;
    if (av == bv) return 3'b010;
    if (signedMode) isLess = ($signed(av) < $signed(bv));
    else            isLess = (av < bv);
    return isLess ? 3'b100 : 3'b001;
  endfunction

  // Chunks examined: the MSB-first scan stops at the chunk holding the
  // highest differing bit (sign-bit inversion cancels in the XOR).
  function automatic int modelChunks(input logic [SIZE-1:0] av,
                                     input logic [SIZE-1:0] bv);
    logic [SIZE-1:0] diff;
    diff = av ^ bv;
    if (diff == '0) return NUM_CHUNKS;
    for (int bitPos = SIZE - 1; bitPos >= 0; bitPos--) begin
      if (diff[bitPos]) return NUM_CHUNKS - (bitPos / CHUNK);
    end
    return NUM_CHUNKS;
  endfunction

  // Runs one compare; injectAt > 0 raises a spurious start after that many
  // post-start edges, which must be ignored.
  task automatic applyStimulus(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                               input logic signedMode, input int injectAt);
    logic [2:0] expFlags;
    int         expChunks;
    int         n;
    bit         seen;
    expFlags  = modelResult(av, bv, signedMode);
    expChunks = modelChunks(av, bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    mode  = signedMode;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    mode  = ~signedMode;
    n    = 0;
    seen = 0;
    while (!seen && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
      if (n == injectAt) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
      end else begin
        checkOutput("busyInCompare", {31'd0, busy}, 32'd1);
        checkOutput("flagsClearInCompare", {29'd0, lt, eq, gt}, 32'd0);
      end
    end
    start = 1'b0;
    if (!seen) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", n + 1, expChunks + 1);
    checkOutput("result", {29'd0, lt, eq, gt}, {29'd0, expFlags});
    checkOutput("busyAtDone", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
    checkOutput("busyAfterDone", {31'd0, busy}, 32'd0);
    checkOutput("resultHeld", {29'd0, lt, eq, gt}, {29'd0, expFlags});
  endtask

  initial begin
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    mode  = 1'b0;
    #1;
    checkOutput("resetOutputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idleAfterReset", {27'd0, busy, done, lt, eq, gt}, 32'd0);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    applyStimulus(32'h8000_0000, 32'h8000_0001, 1'b1, 0);
    applyStimulus(32'h0000_0000, 32'h8000_0000, 1'b1, 0);
    applyStimulus(32'h00AB_0000, 32'h00AC_0000, 1'b0, 0);

    // Spurious start mid-compare, then an immediate back-to-back start.
    applyStimulus(32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'($urandom) >> (CHUNK * $urandom_range(1, NUM_CHUNKS - 1)));
        2:       rb = ra ^ (32'h1 << $urandom_range(0, SIZE - 1));
        default: rb = $urandom;
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a full-length compare.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h1234_5678;
    b     = 32'h1234_5678;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("busyBeforeAbort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("asyncResetOutputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("noDoneAfterAbort", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    end
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
